// File: rtl/dcache_ctrl_if.sv
// CPU-side and memory-side signal bundle for the MEM-stage data cache.
// The slave modport is the cache controller; the master modport is the pipeline plus backing memory.
interface dcache_ctrl_if;
    logic         cpu_req_i;
    logic         cpu_we_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
        output cpu_data_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
        input  cpu_data_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller, 16 sets x 256-bit lines.
// Hits are served combinationally in IDLE; misses stall while evicting/refilling a whole line.
module dcache_ctrl (
    input  logic         clk_i,
    input  logic         rst_i,
    dcache_ctrl_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_WRITEBACK, ST_ALLOCATE} state_t;

    state_t       state_reg, state_next;
    logic [15:0]  valid_reg, dirty_reg;
    logic [22:0]  tag_mem [16];
    logic [3:0]   lat_index_reg;
    logic [22:0]  lat_tag_reg, victim_tag_reg;

    logic [2:0]   req_word;
    logic [3:0]   req_index;
    logic [22:0]  req_tag;
    logic [1:0]   unused_addr_bits;
    logic         hit, store_we, refill_we, latch_en;
    logic [31:0]  hit_words [8];
    logic [255:0] victim_line;

    assign req_word         = bus.cpu_addr_i[4:2];
    assign req_index        = bus.cpu_addr_i[8:5];
    assign req_tag          = bus.cpu_addr_i[31:9];
    assign unused_addr_bits = bus.cpu_addr_i[1:0];

    assign hit = bus.cpu_req_i & valid_reg[req_index] & (tag_mem[req_index] == req_tag);

    // One 16x32 array per word lane so a store touches a single lane and a refill writes all of them.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            logic [31:0] lane_mem [16];

            always_ff @(posedge clk_i) begin
                if (!rst_i && refill_we) begin
                    lane_mem[lat_index_reg] <= bus.mem_data_i[gi*32 +: 32];
                end else if (!rst_i && store_we && (req_word == 3'(gi))) begin
                    lane_mem[req_index] <= bus.cpu_data_i;
                end
            end

            assign hit_words[gi]             = lane_mem[req_index];
            assign victim_line[gi*32 +: 32]  = lane_mem[lat_index_reg];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!rst_i && refill_we) begin
            tag_mem[lat_index_reg] <= lat_tag_reg;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= ST_IDLE;
            valid_reg      <= '0;
            dirty_reg      <= '0;
            lat_index_reg  <= '0;
            lat_tag_reg    <= '0;
            victim_tag_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (latch_en) begin
                lat_index_reg  <= req_index;
                lat_tag_reg    <= req_tag;
                victim_tag_reg <= tag_mem[req_index];
            end
            if (store_we) begin
                dirty_reg[req_index] <= 1'b1;
            end
            if (refill_we) begin
                valid_reg[lat_index_reg] <= 1'b1;
                dirty_reg[lat_index_reg] <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        bus.cpu_data_o  = '0;
        bus.cpu_stall_o = 1'b0;
        bus.mem_req_o   = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_data_o  = '0;
        store_we        = 1'b0;
        refill_we       = 1'b0;
        latch_en        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.cpu_req_i) begin
                    if (hit) begin
                        if (bus.cpu_we_i) begin
                            store_we = 1'b1;
                        end else begin
                            bus.cpu_data_o = hit_words[req_word];
                        end
                    end else begin
                        bus.cpu_stall_o = 1'b1;
                        latch_en        = 1'b1;
                        state_next      = (valid_reg[req_index] & dirty_reg[req_index]) ?
                                          ST_WRITEBACK : ST_ALLOCATE;
                    end
                end
            end
            ST_WRITEBACK: begin
                bus.cpu_stall_o = 1'b1;
                bus.mem_req_o   = 1'b1;
                bus.mem_we_o    = 1'b1;
                bus.mem_addr_o  = {victim_tag_reg, lat_index_reg, 5'b0};
                bus.mem_data_o  = victim_line;
                if (bus.mem_ack_i) begin
                    state_next = ST_ALLOCATE;
                end
            end
            ST_ALLOCATE: begin
                bus.cpu_stall_o = 1'b1;
                bus.mem_req_o   = 1'b1;
                bus.mem_addr_o  = {lat_tag_reg, lat_index_reg, 5'b0};
                if (bus.mem_ack_i) begin
                    refill_we  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a flat word-memory reference plus a per-set tag table predicts
// stalls, memory transactions and load data; a negedge monitor compares whatever the DUT presents.
module tb_dcache_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dcache_ctrl_if bus();
    dcache_ctrl dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [255:0] line;
    } mem_txn_t;

    int           n_cmp = 0;
    int           n_err = 0;
    mem_txn_t     exp_mem_q [$];
    logic [31:0]  exp_load_q [$];
    int           lat_q [$];
    logic [255:0] backing [bit [31:0]];
    logic [31:0]  ref_mem [bit [31:0]];
    bit           m_valid [16];
    bit           m_dirty [16];
    logic [22:0]  m_tag [16];
    bit           auto_en = 1'b1;
    int           n_acc = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] bg_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    function automatic logic [255:0] get_line(input logic [31:0] la);
        logic [255:0] l;
        if (!backing.exists(la)) begin
            for (int i = 0; i < 8; i++) l[i*32 +: 32] = bg_word(la + 32'(i * 4));
            backing[la] = l;
        end
        return backing[la];
    endfunction

    // Architectural value of a word: last store issued, else what backing memory holds.
    function automatic logic [31:0] ref_word(input logic [31:0] wa);
        logic [255:0] l;
        if (ref_mem.exists(wa)) return ref_mem[wa];
        l = get_line({wa[31:5], 5'b0});
        return l[wa[4:2]*32 +: 32];
    endfunction

    task automatic do_access(input bit we, input logic [31:0] addr, input logic [31:0] data,
                             input int l1, input int l2);
        logic [3:0]   idx;
        logic [22:0]  tag;
        logic [31:0]  wa, vaddr;
        logic [255:0] vline;
        mem_txn_t     t;
        int           la, lb, exp_stall, stalls;
        bit           hit;
        idx = addr[8:5];
        tag = addr[31:9];
        wa  = {addr[31:2], 2'b00};
        la  = (l1 < 0) ? int'($urandom_range(0, 3)) : l1;
        lb  = (l2 < 0) ? int'($urandom_range(0, 3)) : l2;
        hit = m_valid[idx] && (m_tag[idx] == tag);
        exp_stall = 0;
        if (!hit) begin
            exp_stall = 1;
            if (m_valid[idx] && m_dirty[idx]) begin
                vaddr = {m_tag[idx], idx, 5'b0};
                for (int i = 0; i < 8; i++) vline[i*32 +: 32] = ref_word(vaddr + 32'(i * 4));
                t.we = 1'b1; t.addr = vaddr; t.line = vline;
                exp_mem_q.push_back(t);
                lat_q.push_back(la);
                exp_stall += la + 1;
                la = lb;
            end
            t.we = 1'b0; t.addr = {tag, idx, 5'b0}; t.line = '0;
            exp_mem_q.push_back(t);
            lat_q.push_back(la);
            exp_stall += la + 1;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
            m_dirty[idx] = 1'b0;
        end
        if (we) begin
            m_dirty[idx] = 1'b1;
            ref_mem[wa]  = data;
        end else begin
            exp_load_q.push_back(ref_word(wa));
        end
        bus.cpu_req_i  = 1'b1;
        bus.cpu_we_i   = we;
        bus.cpu_addr_i = addr;
        bus.cpu_data_i = data;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (!bus.cpu_stall_o) break;
            stalls++;
            if (stalls > 200) begin
                check("stall_timeout", 1'b1, 1'b0);
                break;
            end
        end
        check("stall_cycles", 256'(stalls), 256'(exp_stall));
        n_acc++;
        $display("acc %0d %s addr=%h data=%h hit=%0d stall=%0d exp_stall=%0d",
                 n_acc, we ? "ST" : "LD", addr, data, hit, stalls, exp_stall);
        @(posedge clk); #1;
        bus.cpu_req_i = 1'b0;
        bus.cpu_we_i  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Backing memory model: acks after the latency the stimulus queued for this transaction.
    initial begin : responder
        bit busy;
        int wait_cnt;
        busy = 1'b0;
        wait_cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (auto_en) begin
                bus.mem_ack_i = 1'b0;
                if (busy && !bus.mem_req_o) busy = 1'b0;
                if (bus.mem_req_o && !busy) begin
                    busy = 1'b1;
                    wait_cnt = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
                end
                if (busy) begin
                    if (wait_cnt == 0) begin
                        bus.mem_ack_i = 1'b1;
                        if (bus.mem_we_o) backing[bus.mem_addr_o] = bus.mem_data_o;
                        else bus.mem_data_i = get_line(bus.mem_addr_o);
                        busy = 1'b0;
                    end else begin
                        wait_cnt--;
                    end
                end
            end else begin
                busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : monitor
        mem_txn_t    t;
        logic [31:0] el;
        if (!rst) begin
            if (bus.mem_req_o && bus.mem_ack_i) begin
                if (exp_mem_q.size() == 0) begin
                    check("unexpected_mem_txn", 1'b1, 1'b0);
                end else begin
                    t = exp_mem_q.pop_front();
                    check("mem_we", 256'(bus.mem_we_o), 256'(t.we));
                    check("mem_addr", 256'(bus.mem_addr_o), 256'(t.addr));
                    if (t.we) check("wb_line", bus.mem_data_o, t.line);
                end
            end
            if (bus.cpu_req_i && !bus.cpu_we_i && !bus.cpu_stall_o) begin
                if (exp_load_q.size() == 0) begin
                    check("unexpected_load", 1'b1, 1'b0);
                end else begin
                    el = exp_load_q.pop_front();
                    check("load_data", 256'(bus.cpu_data_o), 256'(el));
                end
            end else begin
                check("data_zero", 256'(bus.cpu_data_o), 256'(0));
            end
            if (!(bus.mem_req_o && bus.mem_we_o)) check("mem_data_zero", bus.mem_data_o, '0);
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [255:0] l;
        logic [31:0]  a;
        bit           w;
        rst = 1'b1;
        bus.cpu_req_i  = 1'b0;
        bus.cpu_we_i   = 1'b0;
        bus.cpu_addr_i = '0;
        bus.cpu_data_i = '0;
        bus.mem_data_i = '0;
        bus.mem_ack_i  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mem_req", 256'(bus.mem_req_o), 256'(0));
        check("rst_mem_we", 256'(bus.mem_we_o), 256'(0));
        check("rst_mem_addr", 256'(bus.mem_addr_o), 256'(0));
        check("rst_stall", 256'(bus.cpu_stall_o), 256'(0));
        @(posedge clk); #1;

        // Cold read miss with a 5-cycle refill, then hits in the same line.
        l = get_line(32'h100);
        l[63:32] = 32'hDEAD_BEEF;
        backing[32'h100] = l;
        do_access(1'b0, 32'h0000_0104, 32'h0, 4, 0);
        do_access(1'b0, 32'h0000_0100, 32'h0, -1, -1);
        do_access(1'b0, 32'h0000_0104, 32'h0, -1, -1);
        do_access(1'b0, 32'h0000_011C, 32'h0, -1, -1);
        // Store hit, then same-set conflict forcing a writeback.
        do_access(1'b1, 32'h0000_0108, 32'h1234_5678, -1, -1);
        do_access(1'b0, 32'h0000_0308, 32'h0, 2, 1);
        // Write miss allocate, readback, then conflict evicting the merged line.
        do_access(1'b1, 32'h0000_2004, 32'hA5A5_A5A5, 1, 0);
        do_access(1'b0, 32'h0000_2004, 32'h0, -1, -1);
        do_access(1'b0, 32'h0000_0004, 32'h0, 0, 3);
        // Zero-latency ack on a clean miss.
        do_access(1'b0, 32'h0000_4020, 32'h0, 0, 0);

        // Reset in the second ALLOCATE cycle, coincident with an ack, then a late ack.
        auto_en = 1'b0;
        bus.cpu_req_i  = 1'b1;
        bus.cpu_we_i   = 1'b0;
        bus.cpu_addr_i = 32'h0000_6040;
        @(negedge clk);
        check("rstmid_miss_stall", 256'(bus.cpu_stall_o), 256'(1));
        @(posedge clk); #1;
        @(negedge clk);
        check("rstmid_alloc_req", 256'(bus.mem_req_o), 256'(1));
        check("rstmid_alloc_addr", 256'(bus.mem_addr_o), 256'(32'h0000_6040));
        @(posedge clk); #1;
        rst = 1'b1;
        bus.mem_ack_i  = 1'b1;
        bus.mem_data_i = {8{32'hBAD0_BAD0}};
        bus.cpu_req_i  = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.mem_ack_i = 1'b0;
        @(negedge clk);
        check("rstmid_req_drop", 256'(bus.mem_req_o), 256'(0));
        check("rstmid_stall", 256'(bus.cpu_stall_o), 256'(0));
        @(posedge clk); #1;
        bus.mem_ack_i = 1'b1;
        @(negedge clk);
        check("late_ack_ignored", 256'(bus.mem_req_o), 256'(0));
        @(posedge clk); #1;
        bus.mem_ack_i = 1'b0;
        auto_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0; m_dirty[i] = 1'b0;
        end
        ref_mem.delete();
        do_access(1'b0, 32'h0000_6040, 32'h0, -1, -1);
        do_access(1'b0, 32'h0000_0104, 32'h0, -1, -1);

        // Random traffic over few tags per set so conflicts and evictions are frequent.
        for (int n = 0; n < 300; n++) begin
            a = {23'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3))};
            w = ($urandom_range(0, 9) < 4);
            do_access(w, a, $urandom(), -1, -1);
            idle(int'($urandom_range(0, 2)));
        end

        idle(4);
        check("mem_queue_drained", 256'(exp_mem_q.size()), 256'(0));
        check("load_queue_drained", 256'(exp_load_q.size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
